// File: rtl/wash_cycle_sequencer.sv
// Washing-machine phase sequencer: fill, wash, rinse, spin, with load counter.
// Optional second wash/rinse pass is built only when DOUBLE_WASH_EN is defined.
module wash_cycle_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  input  logic [3:0] DoneFlags,
  output logic [2:0] current_state,
  output logic       TimerPause,
  output logic       wash_done,
  output logic       second_pass,
  output logic [7:0] load_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL  = 3'b001,
    WASH  = 3'b010,
    RINSE = 3'b011,
    SPIN  = 3'b100
  } state_t;

  localparam logic [3:0] FILL_DONE  = 4'b1000;
  localparam logic [3:0] WASH_DONE  = 4'b0100;
  localparam logic [3:0] RINSE_DONE = 4'b0010;
  localparam logic [3:0] SPIN_DONE  = 4'b0001;

  state_t state;

  assign current_state = state;
  assign TimerPause    = timer_pause & (state == SPIN);

`ifdef DOUBLE_WASH_EN
  logic pending;
`else
  logic unused_double_wash;
  assign unused_double_wash = double_wash;
  assign second_pass = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      wash_done   <= 1'b0;
      load_count  <= 8'd0;
`ifdef DOUBLE_WASH_EN
      pending     <= 1'b0;
      second_pass <= 1'b0;
`endif
    end else begin
      wash_done <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_in) begin
            state <= FILL;
`ifdef DOUBLE_WASH_EN
            pending <= double_wash;
`endif
          end
        end
        FILL: begin
          if (DoneFlags == FILL_DONE)
            state <= WASH;
        end
        WASH: begin
          if (DoneFlags == WASH_DONE)
            state <= RINSE;
        end
        RINSE: begin
          if (DoneFlags == RINSE_DONE) begin
`ifdef DOUBLE_WASH_EN
            if (pending) begin
              state       <= WASH;
              pending     <= 1'b0;
              second_pass <= 1'b1;
            end else begin
              state       <= SPIN;
              second_pass <= 1'b0;
            end
`else
            state <= SPIN;
`endif
          end
        end
        SPIN: begin
          // a pause freezes the phase even if the spin timer expires
          if (DoneFlags == SPIN_DONE && !timer_pause) begin
            state     <= IDLE;
            wash_done <= 1'b1;
            if (load_count != 8'hFF)
              load_count <= load_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
